// File: rtl/adc_if_pkg.sv
// Shared types, frame geometry and control-word helper for the serial ADC interface.
package adc_if_pkg;

  typedef enum logic [1:0] {GAP, LEAD, SHIFT, TRAIL} state_t;

  localparam int unsigned FRAME_BITS   = 16;
  localparam int unsigned ADDR_MSB     = 13;
  localparam int unsigned ADDR_LSB     = 11;
  localparam int unsigned DATA_LSB_BIT = 0;
  localparam int unsigned LEAD_ZEROS   = 4;
  localparam int unsigned CH_W         = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned RESULT_BITS  = FRAME_BITS - LEAD_ZEROS - DATA_LSB_BIT;

  // DIN word: channel address in the ADDR field, every other bit zero.
  function automatic logic [FRAME_BITS-1:0] ctrl_word(input logic [CH_W-1:0] ch);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[ADDR_MSB:ADDR_LSB] = ch;
    return w;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: CLK_DIV clks per half-period, idles high, with one-clk toggle strobes.
module adc_sclk_gen #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold_high,
  output logic sclk,
  output logic rise_c,
  output logic fall_c,
  output logic half_done_c
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;

  // Strobes are true in the cycle whose closing edge toggles sclk.
  assign half_done_c = en && (cnt == CNT_W'(CLK_DIV - 1));
  assign fall_c      = half_done_c && sclk && !hold_high;
  assign rise_c      = half_done_c && !sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else begin
      cnt <= half_done_c ? '0 : cnt + CNT_W'(1);
      if (fall_c || rise_c) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/adc_interface.sv
// SPI master for an 8-channel 12-bit ADC: continuous 16-SCLK frames, tagged samples
// with a one-clk valid strobe.
module adc_interface #(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned DATA_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        switches,
  input  logic              adc_dout,
  output logic              adc_cs,
  output logic              adc_sclk,
  output logic              adc_din,
  output logic [DATA_W-1:0] sample,
  output logic [2:0]        sample_ch,
  output logic              sample_valid
);

  import adc_if_pkg::*;

  localparam int unsigned CNT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_nx;
  logic [CH_W-1:0]         cur_ch, cur_ch_nx, prev_ch, prev_ch_nx;
  logic [FRAME_BITS-1:0]   tx_sr, tx_sr_nx;
  logic [RESULT_BITS-1:0]  rx_sr, rx_sr_nx;
  logic                    adc_cs_nx, adc_din_nx, sample_valid_nx;
  logic [DATA_W-1:0]       sample_nx;
  logic [2:0]              sample_ch_nx;

  logic sclk_en_c, sclk_hold_c, sclk_rise_c, sclk_fall_c, sclk_half_c;

  // SCLK runs through LEAD (first high half) and SHIFT; it stays high after the 16th rise.
  assign sclk_en_c   = (state == LEAD) || (state == SHIFT);
  assign sclk_hold_c = (bit_cnt == BIT_W'(FRAME_BITS));

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (sclk_en_c),
    .hold_high   (sclk_hold_c),
    .sclk        (adc_sclk),
    .rise_c      (sclk_rise_c),
    .fall_c      (sclk_fall_c),
    .half_done_c (sclk_half_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= GAP;
      cnt          <= '0;
      bit_cnt      <= '0;
      cur_ch       <= '0;
      prev_ch      <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      adc_cs       <= 1'b1;
      adc_din      <= 1'b0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      bit_cnt      <= bit_cnt_nx;
      cur_ch       <= cur_ch_nx;
      prev_ch      <= prev_ch_nx;
      tx_sr        <= tx_sr_nx;
      rx_sr        <= rx_sr_nx;
      adc_cs       <= adc_cs_nx;
      adc_din      <= adc_din_nx;
      sample       <= sample_nx;
      sample_ch    <= sample_ch_nx;
      sample_valid <= sample_valid_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    bit_cnt_nx      = bit_cnt;
    cur_ch_nx       = cur_ch;
    prev_ch_nx      = prev_ch;
    tx_sr_nx        = tx_sr;
    rx_sr_nx        = rx_sr;
    adc_cs_nx       = adc_cs;
    adc_din_nx      = adc_din;
    sample_nx       = sample;
    sample_ch_nx    = sample_ch;
    sample_valid_nx = 1'b0;

    case (state)
      GAP: begin
        if (cnt == CNT_W'(GAP_CYC - 1)) begin
          state_nx   = LEAD;
          cnt_nx     = '0;
          bit_cnt_nx = '0;
          cur_ch_nx  = switches;
          tx_sr_nx   = ctrl_word(switches);
          adc_cs_nx  = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      LEAD: begin
        if (sclk_fall_c) begin
          state_nx   = SHIFT;
          adc_din_nx = tx_sr[FRAME_BITS-1];
          tx_sr_nx   = {tx_sr[FRAME_BITS-2:0], 1'b0};
        end
      end
      SHIFT: begin
        if (sclk_fall_c) begin
          adc_din_nx = tx_sr[FRAME_BITS-1];
          tx_sr_nx   = {tx_sr[FRAME_BITS-2:0], 1'b0};
        end
        // The first LEAD_ZEROS returned bits are padding and never enter rx_sr.
        if (sclk_rise_c) begin
          bit_cnt_nx = bit_cnt + BIT_W'(1);
          if (bit_cnt >= BIT_W'(LEAD_ZEROS)) rx_sr_nx = {rx_sr[RESULT_BITS-2:0], adc_dout};
        end
        if (sclk_half_c && sclk_hold_c) begin
          state_nx = TRAIL;
          cnt_nx   = '0;
        end
      end
      TRAIL: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state_nx        = GAP;
          cnt_nx          = '0;
          adc_cs_nx       = 1'b1;
          sample_nx       = DATA_W'(rx_sr);
          sample_ch_nx    = prev_ch;
          prev_ch_nx      = cur_ch;
          sample_valid_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = GAP;
    endcase
  end

endmodule

// File: tb/tb_adc_interface.sv
// Directed bench for adc_interface with a behavioural ADC model feeding a scoreboard.
module tb_adc_interface;

  localparam int unsigned CLK_DIV     = 8;
  localparam int unsigned GAP_CYC     = 4;
  localparam int unsigned DATA_W      = 12;
  localparam int          FRAME_LIMIT = 400;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        switches;
  logic              adc_dout;
  logic              adc_cs, adc_sclk, adc_din, sample_valid;
  logic [DATA_W-1:0] sample;
  logic [2:0]        sample_ch;

  int tests = 0;
  int fails = 0;

  exp_t        sb_q[$];
  logic [15:0] addr_q[$];

  logic [11:0] adc_tab [0:7] = '{12'h123, 12'h3C7, 12'h5AA, 12'h0F0,
                                 12'hFFF, 12'hA5C, 12'h001, 12'h800};

  adc_interface #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .switches     (switches),
    .adc_dout     (adc_dout),
    .adc_cs       (adc_cs),
    .adc_sclk     (adc_sclk),
    .adc_din      (adc_din),
    .sample       (sample),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // ADC model: converts the channel addressed in the previous frame, drives DOUT on SCLK falls.
  logic [15:0] m_word;
  logic [15:0] m_din;
  logic [2:0]  m_prev = 3'd0;
  int          m_bit  = 16;
  logic        cs_q   = 1'b1;
  logic        sclk_q = 1'b1;

  always @(posedge adc_cs or negedge adc_cs or posedge adc_sclk or negedge adc_sclk
           or negedge rst_n) begin
    if (!rst_n) begin
      sb_q.delete();
      addr_q.delete();
      m_prev   = 3'd0;
      m_bit    = 16;
      adc_dout = 1'b0;
    end else begin
      if (cs_q && !adc_cs) begin
        m_word = {4'b0000, adc_tab[m_prev]};
        m_din  = 16'h0000;
        m_bit  = 0;
        sb_q.push_back('{ch: m_prev, data: adc_tab[m_prev]});
      end
      if (!adc_cs && sclk_q && !adc_sclk && m_bit < 16) begin
        adc_dout = m_word[15 - m_bit];
        m_bit++;
      end
      if (!adc_cs && !sclk_q && adc_sclk) m_din = {m_din[14:0], adc_din};
      if (!cs_q && adc_cs) begin
        addr_q.push_back(m_din);
        m_prev = m_din[13:11];
      end
    end
    cs_q   = adc_cs;
    sclk_q = adc_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs until sample_valid, measuring CS/SCLK framing; optionally changes switches mid-frame.
  task automatic wait_frame(input int chg_at, input logic [2:0] chg_val,
                            output int to_fall, output int lo, output int rises,
                            output int span, output bit cs_prev, output bit ok);
    logic prev_sclk;
    int   first_rise, last_rise;
    to_fall = 0; lo = 0; rises = 0; span = 0; ok = 1'b0;
    first_rise = 0; last_rise = 0;
    prev_sclk = adc_sclk;
    cs_prev   = adc_cs;
    for (int i = 1; i <= FRAME_LIMIT; i++) begin
      @(posedge clk);
      #1;
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
      if (!adc_cs) begin
        if (lo == 0) to_fall = i;
        lo++;
        if (lo == chg_at) switches = chg_val;
        if (!prev_sclk && adc_sclk) begin
          if (rises == 0) first_rise = i;
          last_rise = i;
          rises++;
        end
      end
      prev_sclk = adc_sclk;
      cs_prev   = adc_cs;
    end
    span = last_rise - first_rise;
  endtask

  task automatic check_frame(input string name, input int chg_at, input logic [2:0] chg_val,
                             input logic [2:0] exp_ch, input logic [2:0] addr_ch);
    int   to_fall, lo, rises, span;
    bit   cs_prev, ok;
    exp_t e;
    logic [15:0] w;
    wait_frame(chg_at, chg_val, to_fall, lo, rises, span, cs_prev, ok);
    chk({name, "_valid_seen"}, 32'(ok), 32'd1);
    chk({name, "_gap_clks"}, 32'(to_fall), 32'(GAP_CYC));
    chk({name, "_cs_low_clks"}, 32'(lo), 32'(34 * CLK_DIV));
    chk({name, "_sclk_rises"}, 32'(rises), 32'd16);
    chk({name, "_rise_span"}, 32'(span), 32'(15 * 2 * CLK_DIV));
    chk({name, "_cs_low_before_valid"}, 32'(cs_prev), 32'd0);
    chk({name, "_cs_high_at_valid"}, 32'(adc_cs), 32'd1);
    chk({name, "_ch"}, 32'(sample_ch), 32'(exp_ch));
    chk({name, "_sb_present"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({name, "_sample"}, 32'(sample), 32'(e.data));
      chk({name, "_sb_ch"}, 32'(sample_ch), 32'(e.ch));
    end
    chk({name, "_addr_present"}, 32'(addr_q.size() != 0), 32'd1);
    if (addr_q.size() != 0) begin
      w = addr_q.pop_front();
      chk({name, "_din_word"}, 32'(w), 32'({2'b00, addr_ch, 11'b0}));
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    switches = 3'b101;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cs", 32'(adc_cs), 32'd1);
    chk("rst_sclk", 32'(adc_sclk), 32'd1);
    chk("rst_din", 32'(adc_din), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_sample_ch", 32'(sample_ch), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    #18 rst_n = 1'b1;

    check_frame("f1", -1, 3'd0, 3'd0, 3'd5);
    switches = 3'b001;
    check_frame("f2", -1, 3'd0, 3'd5, 3'd1);
    switches = 3'b010;
    check_frame("f3", -1, 3'd0, 3'd1, 3'd2);
    switches = 3'b100;
    check_frame("f4", -1, 3'd0, 3'd2, 3'd4);
    switches = 3'b111;
    check_frame("f5", -1, 3'd0, 3'd4, 3'd7);
    check_frame("f6_midchg", 100, 3'd3, 3'd7, 3'd7);
    check_frame("f7", -1, 3'd0, 3'd7, 3'd3);

    // Abort the next frame with a reset pulse during bit 8 of SHIFT.
    begin
      bit fell = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (!adc_cs) begin
          fell = 1'b1;
          break;
        end
      end
      chk("f8_cs_fell", 32'(fell), 32'd1);
    end
    repeat (128) @(posedge clk);
    #1;
    chk("f8_cs_low_pre_rst", 32'(adc_cs), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("f8_rst_cs_async", 32'(adc_cs), 32'd1);
    chk("f8_rst_sclk", 32'(adc_sclk), 32'd1);
    chk("f8_rst_din", 32'(adc_din), 32'd0);
    chk("f8_rst_sample", 32'(sample), 32'd0);
    chk("f8_rst_sample_ch", 32'(sample_ch), 32'd0);
    switches = 3'b110;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("f8_rst_no_valid", 32'(sample_valid), 32'd0);
      chk("f8_rst_cs_held", 32'(adc_cs), 32'd1);
    end
    rst_n = 1'b1;

    check_frame("f9_post_rst", -1, 3'd0, 3'd0, 3'd6);
    check_frame("f10", -1, 3'd0, 3'd6, 3'd6);
    @(posedge clk);
    #1;
    chk("valid_one_clk", 32'(sample_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
